// File: rtl/duart_multichannel.sv
// Multi-channel 68681-style UART: per-channel mode/status/command registers, baud divisor,
// RX/TX FIFOs, parity/framing status and normal/echo/local-loop/remote-loop modes.
module duart_multichannel #(
  parameter int NCH      = 2,
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 2,
  parameter int DIV_W    = 8,
  parameter int CH_AW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CS,
  input  logic             R_W,
  input  logic [CH_AW+1:0] ADDR,
  inout  wire  [7:0]       DATA,
  input  logic [NCH-1:0]   RX,
  output logic [NCH-1:0]   TX,
  output logic [NCH-1:0]   RXRDY,
  output logic [NCH-1:0]   FFULL,
  output logic [NCH-1:0]   TXRDY,
  output logic [NCH-1:0]   TXEMT
);
  // state  | meaning
  // IDLE   | TX: line high, waiting for FIFO data   RX: waiting for falling edge
  // START  | start bit                              RX: confirm start at mid-bit
  // DATA   | data bits LSB first
  // PAR    | parity bit
  // STOP1/2| TX stop bits                           RX STOP: sample stop, push entry
  // BRK    | RX only: break seen, wait for line high
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3,
                         S_STOP1 = 3'd4, S_STOP2 = 3'd5, S_BRK = 3'd6;
  localparam int RPW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TPW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;

  logic             cs_d, fire;
  logic [CH_AW-1:0] ch_sel;
  logic [1:0]       reg_sel;
  logic [7:0]       rd_ch [NCH];
  logic [7:0]       rd_data;

  assign fire    = CS & ~cs_d;
  assign ch_sel  = ADDR[CH_AW+1:2];
  assign reg_sel = ADDR[1:0];

  always_ff @(posedge CLK) begin
    if (RESET) cs_d <= 1'b0;
    else       cs_d <= CS;
  end

  always_comb begin
    rd_data = 8'h00;
    for (int c = 0; c < NCH; c++)
      if (ch_sel == CH_AW'(c)) rd_data = rd_ch[c];
  end

  assign DATA = (CS & R_W) ? rd_data : 8'bz;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam logic [CH_AW-1:0] CH_ID = CH_AW'(g);
    logic             sel, mr_acc, csr_wr, cr_wr, rhr_rd, thr_wr;
    logic [2:0]       cmd;
    logic [7:0]       mr1, mr2, sr;
    logic             mr_ptr, rx_en, tx_en, ovr, ovr_set;
    logic [DIV_W-1:0] csr, baud_cnt;
    logic             tick, par_en, par_odd;
    logic [1:0]       mode;
    logic [2:0]       last_bit;
    logic [7:0]       mask;

    assign sel      = fire && (ch_sel == CH_ID);
    assign mr_acc   = sel && reg_sel == 2'd0;
    assign csr_wr   = sel && !R_W && reg_sel == 2'd1;
    assign cr_wr    = sel && !R_W && reg_sel == 2'd2;
    assign rhr_rd   = sel && R_W && reg_sel == 2'd3;
    assign thr_wr   = sel && !R_W && reg_sel == 2'd3;
    assign cmd      = cr_wr ? DATA[6:4] : 3'd0;
    assign tick     = (baud_cnt == '0);
    assign mode     = mr2[7:6];
    assign par_en   = mr1[4];
    assign par_odd  = mr1[2];
    assign last_bit = {1'b0, mr1[1:0]} + 3'd4;
    assign mask     = 8'hFF >> (2'd3 - mr1[1:0]);

    // TX FIFO and shifter
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TPW-1:0] tx_wp, tx_rp;
    logic [TCW-1:0] tx_cnt;
    logic           tx_full, tx_empty, tx_push, tx_load, tx_end, tx_bit, tx_q, tx_par;
    logic [2:0]     tx_st, tx_bc;
    logic [3:0]     tx_sub;
    logic [7:0]     tx_sh, tx_data;

    assign tx_full  = (tx_cnt == TCW'(TX_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = thr_wr && tx_en && !tx_full;
    assign tx_end   = tick && tx_sub == 4'hF && tx_st != S_IDLE;
    assign tx_load  = !tx_empty && cmd != 3'd3 && (tx_st == S_IDLE ||
                      (tx_end && ((tx_st == S_STOP1 && !mr2[0]) || tx_st == S_STOP2)));
    assign tx_data  = tx_mem[tx_rp] & mask;
    assign tx_bit   = (tx_st == S_START) ? 1'b0 : (tx_st == S_DATA) ? tx_sh[0] :
                      (tx_st == S_PAR) ? tx_par : 1'b1;

    always_ff @(posedge CLK) begin
      if (tx_push) tx_mem[tx_wp] <= DATA;
    end

    always_ff @(posedge CLK) begin
      if (RESET || cmd == 3'd3) begin
        tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
        tx_st <= S_IDLE; tx_sub <= '0; tx_bc <= '0; tx_sh <= '0; tx_par <= 1'b0;
      end else begin
        if (tx_push) tx_wp <= (tx_wp == TPW'(TX_DEPTH - 1)) ? '0 : tx_wp + 1'b1;
        if (tx_load) tx_rp <= (tx_rp == TPW'(TX_DEPTH - 1)) ? '0 : tx_rp + 1'b1;
        tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_load);
        if (csr_wr) tx_sub <= '0;
        else if (tick && tx_st != S_IDLE) tx_sub <= tx_sub + 4'd1;
        if (tx_load) begin
          tx_st <= S_START; tx_sub <= '0; tx_bc <= '0;
          tx_sh <= tx_data; tx_par <= ^tx_data ^ par_odd;
        end else if (tx_end) begin
          case (tx_st)
            S_START: tx_st <= S_DATA;
            S_DATA: begin
              tx_sh <= tx_sh >> 1;
              tx_bc <= tx_bc + 3'd1;
              if (tx_bc == last_bit) tx_st <= par_en ? S_PAR : S_STOP1;
            end
            S_PAR:   tx_st <= S_STOP1;
            S_STOP1: tx_st <= mr2[0] ? S_STOP2 : S_IDLE;
            default: tx_st <= S_IDLE;
          endcase
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET || cmd == 3'd3) tx_q <= 1'b1;
      else if (mode == 2'b00)   tx_q <= tx_bit;
      else if (mode == 2'b10)   tx_q <= 1'b1;
      else                      tx_q <= RX[g];
    end

    // RX engine and FIFO; entries are {FE, PE, data}
    logic [9:0]     rx_mem [RX_DEPTH];
    logic [9:0]     rx_hd;
    logic [RPW-1:0] rx_wp, rx_rp;
    logic [RCW-1:0] rx_cnt;
    logic           rx_full, rx_empty, rx_push, rx_pop, rx_wr, pop_pend;
    logic           rx_s, rx_d, rx_pe, samp;
    logic [2:0]     rx_st, rx_bc;
    logic [3:0]     rx_sub;
    logic [7:0]     rx_sh;

    assign rx_full  = (rx_cnt == RCW'(RX_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign samp     = tick && rx_sub == 4'd7;
    assign rx_push  = rx_st == S_STOP1 && samp;
    assign rx_pop   = pop_pend && !rx_empty;
    assign rx_wr    = rx_push && (!rx_full || rx_pop);
    assign ovr_set  = rx_push && rx_full && !rx_pop;
    assign rx_hd    = rx_empty ? 10'd0 : rx_mem[rx_rp];

    always_ff @(posedge CLK) begin
      if (rx_wr) rx_mem[rx_wp] <= {~rx_s, rx_pe, rx_sh};
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        rx_s <= 1'b1; rx_d <= 1'b1;
      end else begin
        rx_s <= (mode == 2'b10) ? tx_bit : RX[g];
        rx_d <= rx_s;
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET || cmd == 3'd2) begin
        rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0; pop_pend <= 1'b0;
      end else begin
        pop_pend <= rhr_rd && !rx_empty;
        if (rx_wr)  rx_wp <= (rx_wp == RPW'(RX_DEPTH - 1)) ? '0 : rx_wp + 1'b1;
        if (rx_pop) rx_rp <= (rx_rp == RPW'(RX_DEPTH - 1)) ? '0 : rx_rp + 1'b1;
        rx_cnt <= rx_cnt + RCW'(rx_wr) - RCW'(rx_pop);
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET || cmd == 3'd2 || mode == 2'b11) begin
        rx_st <= S_IDLE; rx_sub <= '0; rx_bc <= '0; rx_sh <= '0; rx_pe <= 1'b0;
      end else begin
        if (csr_wr) rx_sub <= '0;
        else if (tick) rx_sub <= rx_sub + 4'd1;
        case (rx_st)
          S_IDLE: if (rx_en && rx_d && !rx_s) begin
            rx_st <= S_START; rx_sub <= '0; rx_bc <= '0; rx_sh <= '0; rx_pe <= 1'b0;
          end
          S_START: if (samp) rx_st <= rx_s ? S_IDLE : S_DATA;
          S_DATA: if (samp) begin
            rx_sh[rx_bc] <= rx_s;
            rx_bc <= rx_bc + 3'd1;
            if (rx_bc == last_bit) rx_st <= par_en ? S_PAR : S_STOP1;
          end
          S_PAR: if (samp) begin
            rx_pe <= rx_s != (^rx_sh ^ par_odd);
            rx_st <= S_STOP1;
          end
          // a zero stop bit over all-zero data is a break: hold until the line recovers
          S_STOP1: if (samp) rx_st <= (!rx_s && rx_sh == 8'h00) ? S_BRK : S_IDLE;
          S_BRK:   if (rx_s) rx_st <= S_IDLE;
          default: rx_st <= S_IDLE;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) baud_cnt <= '0;
      else if (csr_wr) baud_cnt <= DIV_W'(DATA);
      else if (tick) baud_cnt <= csr;
      else baud_cnt <= baud_cnt - 1'b1;
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        mr1 <= '0; mr2 <= '0; mr_ptr <= 1'b0; csr <= '0;
        rx_en <= 1'b0; tx_en <= 1'b0; ovr <= 1'b0;
      end else begin
        if (mr_acc) begin
          if (!R_W) begin
            if (mr_ptr) mr2 <= DATA;
            else        mr1 <= DATA;
          end
          mr_ptr <= 1'b1;
        end
        if (csr_wr) csr <= DIV_W'(DATA);
        if (cr_wr) begin
          if (DATA[1:0] == 2'b01) rx_en <= 1'b1;
          else if (DATA[1:0] == 2'b10) rx_en <= 1'b0;
          if (DATA[3:2] == 2'b01) tx_en <= 1'b1;
          else if (DATA[3:2] == 2'b10) tx_en <= 1'b0;
        end
        if (ovr_set) ovr <= 1'b1;
        if (cmd == 3'd1) mr_ptr <= 1'b0;
        if (cmd == 3'd2) begin rx_en <= 1'b0; ovr <= 1'b0; end
        if (cmd == 3'd3) tx_en <= 1'b0;
        if (cmd == 3'd4) ovr <= 1'b0;
      end
    end

    assign RXRDY[g] = !rx_empty;
    assign FFULL[g] = rx_full;
    assign TXRDY[g] = tx_en && !tx_full;
    assign TXEMT[g] = tx_en && tx_empty && tx_st == S_IDLE;
    assign TX[g]    = tx_q;
    assign sr       = {1'b0, rx_hd[9], rx_hd[8], ovr, TXEMT[g], TXRDY[g], FFULL[g], RXRDY[g]};
    assign rd_ch[g] = (reg_sel == 2'd0) ? (mr_ptr ? mr2 : mr1) :
                      (reg_sel == 2'd1) ? sr :
                      (reg_sel == 2'd3) ? rx_hd[7:0] : 8'h00;
  end
endmodule

// File: tb/tb_duart_multichannel.sv
// Directed bench for duart_multichannel (2 channels, RX_DEPTH 4, TX_DEPTH 2, CSR 0 => 16 CLK/bit).
module tb_duart_multichannel;
  logic       CLK = 1'b0;
  logic       RESET, CS, R_W;
  logic [2:0] ADDR;
  wire  [7:0] DATA;
  logic [1:0] RX, TX, RXRDY, FFULL, TXRDY, TXEMT;
  logic [7:0] drv;
  logic       drv_en;
  int         n_chk = 0, n_pass = 0;
  logic [7:0] rd;
  logic [9:0] bits;

  assign DATA = drv_en ? drv : 8'bz;
  always #5 CLK = ~CLK;

  duart_multichannel dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .R_W(R_W), .ADDR(ADDR), .DATA(DATA),
    .RX(RX), .TX(TX), .RXRDY(RXRDY), .FFULL(FFULL), .TXRDY(TXRDY), .TXEMT(TXEMT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic bus_wr(input int ch, input int r, input logic [7:0] d);
    @(negedge CLK);
    CS = 1'b1; R_W = 1'b0; ADDR = 3'(ch * 4 + r); drv = d; drv_en = 1'b1;
    @(negedge CLK);
    CS = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_rd(input int ch, input int r, output logic [7:0] d);
    @(negedge CLK);
    CS = 1'b1; R_W = 1'b1; ADDR = 3'(ch * 4 + r);
    #1 d = DATA;
    @(negedge CLK);
    CS = 1'b0; R_W = 1'b0;
  endtask

  task automatic rx_bit(input int ch, input logic b);
    RX[ch] = b;
    repeat (16) @(negedge CLK);
  endtask

  task automatic rx_frame(input int ch, input logic [7:0] d, input logic pen,
                          input logic pb, input logic sb);
    @(negedge CLK);
    rx_bit(ch, 1'b0);
    for (int i = 0; i < 8; i++) rx_bit(ch, d[i]);
    if (pen) rx_bit(ch, pb);
    rx_bit(ch, sb);
    RX[ch] = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic wait_tx_low(input int ch);
    int t = 0;
    while (TX[ch] !== 1'b0 && t < 100) begin @(negedge CLK); t++; end
    chk("tx_start_seen", 32'(t < 100), 32'd1);
  endtask

  task automatic tx_capture(input int ch, output logic [9:0] b);
    b = '0;
    wait_tx_low(ch);
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      b[i] = TX[ch];
      if (i < 9) repeat (16) @(negedge CLK);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    RESET = 1'b1; CS = 1'b0; R_W = 1'b0; ADDR = '0; drv = '0; drv_en = 1'b0; RX = 2'b11;
    repeat (4) @(negedge CLK);
    chk("rst_tx", TX, 2'b11);
    chk("rst_flags", {RXRDY, FFULL, TXRDY, TXEMT}, 8'h00);
    RESET = 1'b0;
    bus_rd(0, 1, rd); chk("rst_sr0", rd, 8'h00);
    bus_rd(1, 0, rd); chk("rst_mr1", rd, 8'h00);

    // ch1: 8N1 transmit of 0x55
    bus_wr(1, 2, 8'h10); bus_wr(1, 0, 8'h03); bus_wr(1, 0, 8'h00);
    bus_wr(1, 1, 8'h00); bus_wr(1, 2, 8'h05);
    chk("tx1_rdy_emt", {TXRDY[1], TXEMT[1]}, 2'b11);
    bus_wr(1, 3, 8'h55);
    tx_capture(1, bits);
    chk("tx1_frame", bits, 10'b1010101010);
    repeat (12) @(negedge CLK);
    chk("tx1_emt_after", TXEMT[1], 1'b1);

    // ch0 local loop of 0xA5
    bus_wr(0, 2, 8'h10); bus_wr(0, 0, 8'h03); bus_wr(0, 0, 8'h80);
    bus_wr(0, 1, 8'h00); bus_wr(0, 2, 8'h05);
    bus_wr(0, 3, 8'hA5);
    t = 0;
    while (RXRDY[0] !== 1'b1 && t < 400) begin @(negedge CLK); t++; end
    chk("ll_rxrdy", 32'(t < 400), 32'd1);
    chk("ll_tx_pin", TX[0], 1'b1);
    bus_rd(0, 1, rd); chk("ll_sr", rd & 8'h61, 8'h01);
    bus_rd(0, 3, rd); chk("ll_rhr", rd, 8'hA5);
    repeat (2) @(negedge CLK);
    chk("ll_rxrdy_clr", RXRDY[0], 1'b0);

    // ch0 normal mode, overrun with five chars into four entries
    bus_wr(0, 0, 8'h00);
    rx_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    rx_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    rx_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
    chk("ffull_at3", FFULL[0], 1'b0);
    rx_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);
    chk("ffull_at4", FFULL[0], 1'b1);
    rx_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    bus_rd(0, 1, rd); chk("ovr_sr", rd, 8'h1F);
    bus_rd(0, 3, rd); chk("ovr_rd0", rd, 8'h11);
    bus_rd(0, 3, rd); chk("ovr_rd1", rd, 8'h22);
    bus_rd(0, 3, rd); chk("ovr_rd2", rd, 8'h33);
    bus_rd(0, 3, rd); chk("ovr_rd3", rd, 8'h44);
    bus_wr(0, 2, 8'h40);
    bus_rd(0, 1, rd); chk("ovr_clr_sr", rd, 8'h0C);
    bus_rd(0, 3, rd); chk("empty_rhr", rd, 8'h00);

    // ch0 odd parity: bad parity entry, good entry, framing error entry
    bus_wr(0, 2, 8'h10); bus_wr(0, 0, 8'h17);
    rx_frame(0, 8'h0F, 1'b1, 1'b0, 1'b1);
    rx_frame(0, 8'h07, 1'b1, 1'b0, 1'b1);
    rx_frame(0, 8'h5A, 1'b1, 1'b1, 1'b0);
    bus_rd(0, 1, rd); chk("pe_sr_bad", rd & 8'h60, 8'h20);
    bus_rd(0, 3, rd); chk("pe_rhr_bad", rd, 8'h0F);
    bus_rd(0, 1, rd); chk("pe_sr_good", rd & 8'h60, 8'h00);
    bus_rd(0, 3, rd); chk("pe_rhr_good", rd, 8'h07);
    bus_rd(0, 1, rd); chk("fe_sr", rd & 8'h60, 8'h40);
    bus_rd(0, 3, rd); chk("fe_rhr", rd, 8'h5A);

    // ch0 auto echo: TX follows RX
    bus_wr(0, 0, 8'h40);
    RX[0] = 1'b0;
    repeat (3) @(negedge CLK);
    chk("echo_low", TX[0], 1'b0);
    RX[0] = 1'b1;
    repeat (3) @(negedge CLK);
    chk("echo_high", TX[0], 1'b1);

    // ch1 MR pointer behaviour
    bus_wr(1, 2, 8'h10); bus_wr(1, 0, 8'h03); bus_wr(1, 0, 8'h01);
    bus_rd(1, 0, rd); chk("mr_rd_a", rd, 8'h01);
    bus_rd(1, 0, rd); chk("mr_rd_b", rd, 8'h01);
    bus_wr(1, 2, 8'h10);
    bus_rd(1, 0, rd); chk("mr_rd_ptr", rd, 8'h03);

    // reset in the middle of a ch1 frame
    bus_wr(1, 3, 8'h55);
    wait_tx_low(1);
    repeat (20) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_tx", TX, 2'b11);
    chk("midrst_flags", {TXRDY, TXEMT, RXRDY}, 6'b0);
    @(negedge CLK);
    RESET = 1'b0;
    bus_rd(1, 1, rd); chk("midrst_sr1", rd, 8'h00);
    bus_rd(0, 1, rd); chk("midrst_sr0", rd, 8'h00);
    bus_wr(1, 0, 8'h07);
    bus_rd(1, 0, rd); chk("midrst_mrptr", rd, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
